// File: rtl/alu_pwr_pkg.sv
// Shared encodings and default timing for the ALU power-domain sequencer.
// The ALU testbench imports this package as well.
package alu_pwr_pkg;

  localparam int unsigned CNT_W        = 4;
  localparam int unsigned ISO_CYC_DEF  = 2;
  localparam int unsigned SAVE_CYC_DEF = 1;
  localparam int unsigned PDN_CYC_DEF  = 4;
  localparam int unsigned PUP_CYC_DEF  = 8;
  localparam int unsigned RST_CYC_DEF  = 1;

  typedef enum logic [2:0] {
    ST_ON        = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_ISO       = 3'd2,
    ST_SAVE      = 3'd3,
    ST_PDN       = 3'd4,
    ST_OFF       = 3'd5,
    ST_PUP       = 3'd6,
    ST_RESTORE   = 3'd7
  } pwr_state_e;

  typedef struct packed {
    logic alu_pwr_en;
    logic iso_en;
    logic save;
    logic restore;
  } pwr_ctl_t;

  // Per-state drive of the power-domain controls.
  function automatic pwr_ctl_t decode_ctl(input pwr_state_e st);
    pwr_ctl_t c;
    c = '0;
    case (st)
      ST_ON, ST_WAIT_IDLE: c.alu_pwr_en = 1'b1;
      ST_ISO, ST_PUP: begin
        c.alu_pwr_en = 1'b1;
        c.iso_en     = 1'b1;
      end
      ST_SAVE: begin
        c.alu_pwr_en = 1'b1;
        c.iso_en     = 1'b1;
        c.save       = 1'b1;
      end
      ST_PDN, ST_OFF: c.iso_en = 1'b1;
      ST_RESTORE: begin
        c.alu_pwr_en = 1'b1;
        c.iso_en     = 1'b1;
        c.restore    = 1'b1;
      end
      default: c.alu_pwr_en = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pwr_timer.sv
// Down-counter timing the fixed-length phases of the power sequence.
module pwr_timer
  import alu_pwr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// ALU power-domain sequencer: isolate, save, power down, and the reverse on wake.
// All outputs are registered from the next state so they move with pwr_state.
module alu_pwr_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int unsigned ISO_CYC  = ISO_CYC_DEF,
  parameter int unsigned SAVE_CYC = SAVE_CYC_DEF,
  parameter int unsigned PDN_CYC  = PDN_CYC_DEF,
  parameter int unsigned PUP_CYC  = PUP_CYC_DEF,
  parameter int unsigned RST_CYC  = RST_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       start_block,
  output logic       sleep_ack,
  output logic       wake_ack,
  output logic [2:0] pwr_state
);

  localparam logic [CNT_W-1:0] ISO_LD  = CNT_W'(ISO_CYC - 1);
  localparam logic [CNT_W-1:0] SAVE_LD = CNT_W'(SAVE_CYC - 1);
  localparam logic [CNT_W-1:0] PDN_LD  = CNT_W'(PDN_CYC - 1);
  localparam logic [CNT_W-1:0] PUP_LD  = CNT_W'(PUP_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYC - 1);

  pwr_state_e       state_q;
  pwr_state_e       state_n;
  pwr_ctl_t         ctl_n;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero_c;

  pwr_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero_c)
  );

  // State and output registers; reset leaves the domain powered and unclamped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ON;
      alu_pwr_en  <= 1'b1;
      iso_en      <= 1'b0;
      save        <= 1'b0;
      restore     <= 1'b0;
      start_block <= 1'b0;
      sleep_ack   <= 1'b0;
      wake_ack    <= 1'b0;
    end else begin
      state_q     <= state_n;
      alu_pwr_en  <= ctl_n.alu_pwr_en;
      iso_en      <= ctl_n.iso_en;
      save        <= ctl_n.save;
      restore     <= ctl_n.restore;
      start_block <= (state_n != ST_ON);
      sleep_ack   <= (state_n == ST_OFF) && (state_q != ST_OFF);
      wake_ack    <= (state_n == ST_ON) && (state_q == ST_RESTORE);
    end
  end

  // Next state; each timed phase loads its length on entry and leaves at zero.
  always_comb begin
    state_n  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_ON: begin
        if (sleep_req) state_n = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!sleep_req) begin
          state_n = ST_ON;
        end else if (!alu_busy) begin
          state_n  = ST_ISO;
          tmr_load = 1'b1;
          tmr_val  = ISO_LD;
        end
      end
      ST_ISO: begin
        if (tmr_zero_c) begin
          state_n  = ST_SAVE;
          tmr_load = 1'b1;
          tmr_val  = SAVE_LD;
        end
      end
      ST_SAVE: begin
        if (tmr_zero_c) begin
          state_n  = ST_PDN;
          tmr_load = 1'b1;
          tmr_val  = PDN_LD;
        end
      end
      ST_PDN: begin
        if (tmr_zero_c) state_n = ST_OFF;
      end
      ST_OFF: begin
        if (wake_req) begin
          state_n  = ST_PUP;
          tmr_load = 1'b1;
          tmr_val  = PUP_LD;
        end
      end
      ST_PUP: begin
        if (tmr_zero_c) begin
          state_n  = ST_RESTORE;
          tmr_load = 1'b1;
          tmr_val  = RST_LD;
        end
      end
      ST_RESTORE: begin
        if (tmr_zero_c) state_n = ST_ON;
      end
      default: state_n = ST_ON;
    endcase
    ctl_n = decode_ctl(state_n);
  end

  assign pwr_state = state_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Self-checking bench for alu_pwr_ctrl: per-edge stimulus/expectation queues
// built from the phase lengths, plus continuous ordering invariants.
module tb_alu_pwr_ctrl;
  import alu_pwr_pkg::*;

  localparam int N_ISO  = int'(ISO_CYC_DEF);
  localparam int N_SAVE = int'(SAVE_CYC_DEF);
  localparam int N_PDN  = int'(PDN_CYC_DEF);
  localparam int N_PUP  = int'(PUP_CYC_DEF);
  localparam int N_RST  = int'(RST_CYC_DEF);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sleep_req = 1'b0;
  logic       wake_req = 1'b0;
  logic       alu_busy = 1'b0;
  logic       alu_pwr_en, iso_en, save, restore;
  logic       start_block, sleep_ack, wake_ack;
  logic [2:0] pwr_state;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_st = 0;
  int sq[$], wq[$], bq[$], eq[$];

  alu_pwr_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sleep_req   (sleep_req),
    .wake_req    (wake_req),
    .alu_busy    (alu_busy),
    .alu_pwr_en  (alu_pwr_en),
    .iso_en      (iso_en),
    .save        (save),
    .restore     (restore),
    .start_block (start_block),
    .sleep_ack   (sleep_ack),
    .wake_ack    (wake_ack),
    .pwr_state   (pwr_state)
  );

  always #5 clk = ~clk;

  wire [9:0] obs = {pwr_state, alu_pwr_en, iso_en, save, restore,
                    start_block, sleep_ack, wake_ack};

  // Expected output vector for a state, given the state of the previous cycle.
  function automatic logic [9:0] exp_vec(int st, int prev);
    logic [3:0] o;
    case (st)
      0, 1:    o = 4'b1000;
      2, 6:    o = 4'b1100;
      3:       o = 4'b1110;
      4, 5:    o = 4'b0100;
      7:       o = 4'b1101;
      default: o = 4'bxxxx;
    endcase
    return {3'(st), o, (st != 0), (st == 5 && prev != 5), (st == 0 && prev == 7)};
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 1));
  endfunction

  function automatic void clear_q();
    sq.delete(); wq.delete(); bq.delete(); eq.delete();
  endfunction

  // One edge: inputs applied before it and the state expected after it.
  function automatic void add(int s, int w, int b, int st);
    sq.push_back(s); wq.push_back(w); bq.push_back(b); eq.push_back(st);
  endfunction

  // Edges whose inputs are sampled in timed states, so any value is ignored.
  function automatic void add_n(int st, int n);
    for (int i = 0; i < n; i++) add(rnd(), rnd(), rnd(), st);
  endfunction

  // From ON: w cycles in WAIT_IDLE (busy holds it), then the fixed path to OFF.
  function automatic void build_sleep(int w);
    add(1, rnd(), rnd(), 1);
    for (int j = 1; j < w; j++) add(1, rnd(), 1, 1);
    add(1, rnd(), 0, 2);
    add_n(2, N_ISO - 1);
    add_n(3, N_SAVE);
    add_n(4, N_PDN);
    add_n(5, 1);
  endfunction

  // From OFF: d idle cycles with sleep noise, then wake through to ON.
  function automatic void build_wake(int d);
    for (int j = 0; j < d; j++) add(rnd(), 0, rnd(), 5);
    add(rnd(), 1, rnd(), 6);
    add_n(6, N_PUP - 1);
    add_n(7, N_RST);
    add_n(0, 1);
  endfunction

  // From ON: a cycles in WAIT_IDLE, then sleep_req withdrawn.
  function automatic void build_abort(int a);
    add(1, rnd(), rnd(), 1);
    for (int j = 1; j < a; j++) add(1, rnd(), 1, 1);
    add(0, rnd(), rnd(), 0);
  endfunction

  // Ordering and pulse-shape invariants, sampled on the falling edge.
  logic p_iso = 1'b0, p_pwr = 1'b1, p_rst = 1'b0, p_sack = 1'b0, p_wack = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_iso = 1'b0; p_pwr = 1'b1; p_rst = 1'b0; p_sack = 1'b0; p_wack = 1'b0;
    end else begin
      n_cmp = n_cmp + 7;
      if (save && restore) begin
        n_bad++; $display("FAIL inv_save_restore: save=%b restore=%b required not both", save, restore);
      end
      if ((save || restore) && !alu_pwr_en) begin
        n_bad++; $display("FAIL inv_pwr_en: alu_pwr_en=%b required 1 with save/restore", alu_pwr_en);
      end
      if (start_block !== (pwr_state != 3'd0)) begin
        n_bad++; $display("FAIL inv_start_block: start_block=%b state=%0d", start_block, pwr_state);
      end
      if (save && !p_iso) begin
        n_bad++; $display("FAIL inv_iso_before_save: prior iso_en=%b required 1", p_iso);
      end
      if (!alu_pwr_en && p_pwr && !p_iso) begin
        n_bad++; $display("FAIL inv_iso_before_pdn: prior iso_en=%b required 1", p_iso);
      end
      if (!iso_en && p_iso && !p_rst) begin
        n_bad++; $display("FAIL inv_iso_release: prior restore=%b required 1", p_rst);
      end
      if ((sleep_ack && p_sack) || (wake_ack && p_wack)) begin
        n_bad++; $display("FAIL inv_ack_width: sleep_ack=%b wake_ack=%b held 2 cycles", sleep_ack, wake_ack);
      end
      p_iso = iso_en; p_pwr = alu_pwr_en; p_rst = restore;
      p_sack = sleep_ack; p_wack = wake_ack;
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== exp_vec(0, 0)) begin
      n_bad++; $display("FAIL reset_async: got %b required %b", obs, exp_vec(0, 0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== exp_vec(0, 0)) begin
      n_bad++; $display("FAIL reset_release: got %b required %b", obs, exp_vec(0, 0));
    end
    prev_st = 0;
  endtask

  task automatic test_sleep();
    clear_q();
    build_sleep(1);
    for (int j = 0; j < 3; j++) add(1, 0, 0, 5);
    for (int i = 0; i < eq.size(); i++) begin
      sleep_req = sq[i][0]; wake_req = wq[i][0]; alu_busy = bq[i][0];
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp_vec(eq[i], prev_st)) begin
        n_bad++; $display("FAIL sleep cyc%0d: got %b required %b", i, obs, exp_vec(eq[i], prev_st));
      end
      prev_st = eq[i];
    end
  endtask

  task automatic test_wake();
    clear_q();
    build_wake(0);
    for (int j = 0; j < 3; j++) add(0, 1, rnd(), 0);
    for (int i = 0; i < eq.size(); i++) begin
      sleep_req = sq[i][0]; wake_req = wq[i][0]; alu_busy = bq[i][0];
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp_vec(eq[i], prev_st)) begin
        n_bad++; $display("FAIL wake cyc%0d: got %b required %b", i, obs, exp_vec(eq[i], prev_st));
      end
      prev_st = eq[i];
    end
  endtask

  task automatic test_busy();
    clear_q();
    build_sleep(5);
    build_wake(2);
    for (int i = 0; i < eq.size(); i++) begin
      sleep_req = sq[i][0]; wake_req = wq[i][0]; alu_busy = bq[i][0];
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp_vec(eq[i], prev_st)) begin
        n_bad++; $display("FAIL busy cyc%0d: got %b required %b", i, obs, exp_vec(eq[i], prev_st));
      end
      prev_st = eq[i];
    end
  endtask

  task automatic test_abort();
    clear_q();
    build_abort(1);
    build_abort(3);
    for (int j = 0; j < 2; j++) add(0, 0, 0, 0);
    for (int i = 0; i < eq.size(); i++) begin
      sleep_req = sq[i][0]; wake_req = wq[i][0]; alu_busy = bq[i][0];
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp_vec(eq[i], prev_st)) begin
        n_bad++; $display("FAIL abort cyc%0d: got %b required %b", i, obs, exp_vec(eq[i], prev_st));
      end
      prev_st = eq[i];
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    add(1, 0, 0, 1);
    add(1, 0, 0, 2);
    add_n(2, N_ISO - 1);
    add_n(3, N_SAVE);
    add_n(4, 2);
    for (int i = 0; i < eq.size(); i++) begin
      sleep_req = sq[i][0]; wake_req = wq[i][0]; alu_busy = bq[i][0];
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp_vec(eq[i], prev_st)) begin
        n_bad++; $display("FAIL rstmid_pre cyc%0d: got %b required %b", i, obs, exp_vec(eq[i], prev_st));
      end
      prev_st = eq[i];
    end
    sleep_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== exp_vec(0, 0)) begin
      n_bad++; $display("FAIL rstmid_async: got %b required %b", obs, exp_vec(0, 0));
    end
    sleep_req = 1'b0; wake_req = 1'b0;
    #9 rst_n = 1'b1;
    prev_st = 0;
    clear_q();
    for (int j = 0; j < 3; j++) add(0, 1, rnd(), 0);
    for (int i = 0; i < eq.size(); i++) begin
      sleep_req = sq[i][0]; wake_req = wq[i][0]; alu_busy = bq[i][0];
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp_vec(eq[i], prev_st)) begin
        n_bad++; $display("FAIL rstmid_post cyc%0d: got %b required %b", i, obs, exp_vec(eq[i], prev_st));
      end
      prev_st = eq[i];
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int e = 0; e < 10; e++) begin
      if ($urandom_range(0, 3) == 0) begin
        build_abort(int'($urandom_range(1, 4)));
      end else begin
        build_sleep(int'($urandom_range(1, 6)));
        build_wake(int'($urandom_range(0, 3)));
      end
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) add(0, rnd(), rnd(), 0);
    end
    for (int i = 0; i < eq.size(); i++) begin
      sleep_req = sq[i][0]; wake_req = wq[i][0]; alu_busy = bq[i][0];
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp_vec(eq[i], prev_st)) begin
        n_bad++; $display("FAIL random cyc%0d: got %b required %b", i, obs, exp_vec(eq[i], prev_st));
      end
      prev_st = eq[i];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sleep();
    test_wake();
    test_busy();
    test_abort();
    test_reset_mid();
    test_random();
    sleep_req = 1'b0; wake_req = 1'b0; alu_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
